class_search_ctrl: RTL and testbench
====================================

Name: class_search_ctrl

Overview:
- Sequencer that owns the class hypervector generator (ROM addressed by frame_id/frame_index) and runs associative search.
- Buffers one query hypervector, arriving as NUM_FRAMES frames of DI_PARALLEL_W_BITS bits.
- Sweeps every class and frame through the generator, accumulating Hamming distance per class.
- Returns the class with minimum distance over a valid/ready result handshake. Sits between the encoder output and the inference result port.

Parameters:
- DI_PARALLEL_W_BITS, 64, frame width in bits.
- NUM_CLASSES, 8, number of class vectors; frame_id width = $clog2(NUM_CLASSES) = 3.
- NUM_FRAMES, 3, frames per hypervector; frame_index width = 2.
- DIST_W, $clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1) = 8, distance width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- query_valid  in  1  query frame valid.
- query_ready  out  1  controller accepts a query frame.
- query_frame  in  DI_PARALLEL_W_BITS  query frame; frames arrive in order, index 0 first.
- frame_id  out  3  class address to the generator.
- frame_index  out  2  frame address to the generator.
- class_vec_in  in  DI_PARALLEL_W_BITS  generator data; combinational from frame_id/frame_index.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_class  out  3  winning class.
- result_dist  out  DIST_W  winning Hamming distance.
- busy  out  1  high in SEARCH and DRAIN.

Behaviour:
- Reset (async, rst_n low):
  - state = LOAD; all counters = 0.
  - query_ready = 0 during reset, 1 from the first cycle after release.
  - frame_id = 0, frame_index = 0.
  - result_valid = 0, result_class = 0, result_dist = 0, busy = 0.
  - Query buffer and accumulators = 0.
- LOAD:
  - query_ready = 1.
  - On each query_valid & query_ready edge, store query_frame into buffer[load_cnt] and increment load_cnt.
  - Gaps in query_valid are allowed.
  - On the handshake with load_cnt == NUM_FRAMES-1: go to SEARCH, clear load_cnt, cls_cnt, frm_cnt.
- SEARCH:
  - query_ready = 0.
  - frame_id = cls_cnt and frame_index = frm_cnt, both driven from registers.
  - Every cycle, register stage S1 = popcount(class_vec_in XOR buffer[frm_cnt]), plus tags cls, last_frame = (frm_cnt == NUM_FRAMES-1), and s1_valid.
  - frm_cnt wraps NUM_FRAMES-1 -> 0 and increments cls_cnt.
  - After issuing (NUM_CLASSES-1, NUM_FRAMES-1), go to DRAIN. Address outputs return to 0.
- Accumulate, on each s1_valid:
  - acc += S1 popcount; acc is cleared when a new class begins.
  - On last_frame, compare acc+S1 against best_dist.
  - Update best_class/best_dist if strictly less, or if this is class 0. Ties keep the lower class index.
- DRAIN:
  - One cycle for the final S1 entry.
  - Then go to DONE, loading result_class and result_dist from best.
- DONE:
  - result_valid = 1; result_class and result_dist stay stable while result_ready = 0.
  - On the result_valid & result_ready edge: result_valid -> 0, state -> LOAD.
- Latency: result_valid rises exactly NUM_CLASSES*NUM_FRAMES+2 = 26 cycles after the edge on which the last query frame is accepted.
- Widths:
  - Popcount of one frame fits in 7 bits; the accumulator is DIST_W bits and never overflows (max 192).
- Boundary conditions:
  - query_valid while busy or in DONE: ignored (query_ready = 0), no state change.
  - rst_n asserted mid-SEARCH or in DONE: immediate return to reset values. The partial query is discarded and no result is emitted.
  - NUM_FRAMES = 1: frm_cnt is constant 0, and every S1 entry is last_frame.

Decomposition:
- Package hdc_search_pkg: constants CLS_W, FRM_W, DIST_W derived from the parameters above; typedef enum logic [1:0] {LOAD, SEARCH, DRAIN, DONE} search_state_t.
- Sub-module hv_popcount:
  - Combinational popcount of a DI_PARALLEL_W_BITS vector.
  - Adder tree, output width $clog2(DI_PARALLEL_W_BITS+1).
  - Instantiated once.
- The class vector generator is instantiated outside this block, at the level above.

Test Plan:
- Load the three frames of class 1, each equal to 64'hD9BFE198D232075B -> result_class = 1, result_dist = 0; result_valid exactly 26 cycles after the last query handshake.
- Load the class 0 frames, 64'h74C27F4985AC5CFA / 64'h66C27F4985AC5CFA / 64'h74C27F4985AC5CFA -> result_class = 0, result_dist = 0.
- Load the class 1 frames with bit 0 of frame 2 flipped -> result_class = 1, result_dist = 1.
- Tie check:
  - Query all-zeros, compared against a golden model (per-class popcount, minimum, lowest index on tie) -> exact class and distance match.
  - Force a tie with a bench-side substitute ROM in which classes 2 and 5 are identical -> result_class = 2.
- Backpressure and ignored queries:
  - Hold result_ready = 0 for 10 cycles -> result_valid, result_class, result_dist stable; query_ready = 0.
  - query_valid pulses during SEARCH and DONE are ignored.
  - The next query is processed correctly after the handshake.
- Reset mid-operation:
  - Drive rst_n low during cycle 10 of SEARCH -> all outputs return to reset values asynchronously; no result_valid.
  - A fresh 3-frame query then yields a correct result.
  - A query delivered with 1-3 idle cycles between frames produces an identical result.

Source files
------------

// File: rtl/hdc_search_pkg.sv
// Shared constants and types for the class search controller.
// Sizes are derived from the frame width, class count and frame count.
package hdc_search_pkg;

    localparam int DI_PARALLEL_W_BITS = 64;
    localparam int NUM_CLASSES        = 8;
    localparam int NUM_FRAMES         = 3;

    localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int FRM_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DIST_W = $clog2(NUM_FRAMES * DI_PARALLEL_W_BITS + 1);
    localparam int PC_W   = $clog2(DI_PARALLEL_W_BITS + 1);

    typedef enum logic [1:0] {
        LOAD,
        SEARCH,
        DRAIN,
        DONE
    } search_state_t;

endpackage

// File: rtl/hv_popcount.sv
// Combinational popcount of one hypervector frame using a binary adder tree.
// Ports: vec_i (frame to count), cnt_o (number of set bits).
module hv_popcount #(
    parameter int W  = 64,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [OW-1:0] cnt_o
);

    localparam int LV = (W > 1) ? $clog2(W) : 1;
    localparam int N  = 1 << LV;

    // Heap-ordered tree: node[1] is the root, leaves sit at N..2N-1.
    logic [OW-1:0] node [1:2*N-1];

    genvar i;
    for (i = 0; i < N; i++) begin : g_leaf
        if (i < W) begin : g_bit
            assign node[N+i] = OW'(vec_i[i]);
        end else begin : g_pad
            assign node[N+i] = '0;
        end
    end

    for (i = 1; i < N; i++) begin : g_sum
        assign node[i] = node[2*i] + node[2*i+1];
    end

    assign cnt_o = node[1];

endmodule

// File: rtl/class_search_ctrl.sv
// Associative search sequencer: buffers a query, sweeps the class generator and
// returns the class with the smallest Hamming distance.
// Ports: query_valid/query_ready/query_frame (query in), frame_id/frame_index
// (generator address), class_vec_in (generator data), result_valid/result_ready/
// result_class/result_dist (result out), busy (search in progress).
module class_search_ctrl
    import hdc_search_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          query_valid,
    output logic                          query_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] query_frame,
    output logic [CLS_W-1:0]              frame_id,
    output logic [FRM_W-1:0]              frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [CLS_W-1:0]              result_class,
    output logic [DIST_W-1:0]             result_dist,
    output logic                          busy
);

    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);

    search_state_t state_q;

    logic [DI_PARALLEL_W_BITS-1:0] buf_q [NUM_FRAMES];
    logic [FRM_W-1:0]              load_q;
    logic [CLS_W-1:0]              cls_q;
    logic [FRM_W-1:0]              frm_q;

    logic                          s1_valid_q;
    logic [PC_W-1:0]               s1_pop_q;
    logic [CLS_W-1:0]              s1_cls_q;
    logic                          s1_first_q;
    logic                          s1_last_q;

    logic [DIST_W-1:0]             acc_q;
    logic [CLS_W-1:0]              best_class_q;
    logic [DIST_W-1:0]             best_dist_q;

    logic                          query_ready_q;
    logic                          result_valid_q;
    logic [CLS_W-1:0]              result_class_q;
    logic [DIST_W-1:0]             result_dist_q;
    logic                          busy_q;

    logic [PC_W-1:0]               pop_d;
    logic [DIST_W-1:0]             acc_d;

    hv_popcount #(
        .W  (DI_PARALLEL_W_BITS),
        .OW (PC_W)
    ) u_popcount (
        .vec_i (class_vec_in ^ buf_q[frm_q]),
        .cnt_o (pop_d)
    );

    // A first-frame entry starts a fresh class sum.
    assign acc_d = (s1_first_q ? '0 : acc_q) + DIST_W'(s1_pop_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            for (int f = 0; f < NUM_FRAMES; f++) begin
                buf_q[f] <= '0;
            end
            load_q         <= '0;
            cls_q          <= '0;
            frm_q          <= '0;
            s1_valid_q     <= 1'b0;
            s1_pop_q       <= '0;
            s1_cls_q       <= '0;
            s1_first_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            acc_q          <= '0;
            best_class_q   <= '0;
            best_dist_q    <= '0;
            query_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_dist_q  <= '0;
            busy_q         <= 1'b0;
        end else begin
            s1_valid_q <= 1'b0;

            if (s1_valid_q) begin
                acc_q <= acc_d;
                // Class 0 seeds the minimum; strict less-than keeps the lower index on ties.
                if (s1_last_q && (acc_d < best_dist_q || s1_cls_q == '0)) begin
                    best_class_q <= s1_cls_q;
                    best_dist_q  <= acc_d;
                end
            end

            unique case (state_q)
                LOAD: begin
                    query_ready_q <= 1'b1;
                    if (query_valid && query_ready_q) begin
                        buf_q[load_q] <= query_frame;
                        if (load_q == FRM_LAST) begin
                            state_q       <= SEARCH;
                            load_q        <= '0;
                            cls_q         <= '0;
                            frm_q         <= '0;
                            query_ready_q <= 1'b0;
                            busy_q        <= 1'b1;
                        end else begin
                            load_q <= load_q + 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    s1_valid_q <= 1'b1;
                    s1_pop_q   <= pop_d;
                    s1_cls_q   <= cls_q;
                    s1_first_q <= (frm_q == '0);
                    s1_last_q  <= (frm_q == FRM_LAST);
                    if (frm_q == FRM_LAST) begin
                        frm_q <= '0;
                        if (cls_q == CLS_LAST) begin
                            cls_q   <= '0;
                            state_q <= DRAIN;
                        end else begin
                            cls_q <= cls_q + 1'b1;
                        end
                    end else begin
                        frm_q <= frm_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait until the last S1 entry has been folded into best.
                    if (!s1_valid_q) begin
                        state_q        <= DONE;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_class_q <= best_class_q;
                        result_dist_q  <= best_dist_q;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_q        <= LOAD;
                        result_valid_q <= 1'b0;
                        query_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign query_ready  = query_ready_q;
    assign frame_id     = cls_q;
    assign frame_index  = frm_q;
    assign result_valid = result_valid_q;
    assign result_class = result_class_q;
    assign result_dist  = result_dist_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_class_search_ctrl.sv
// Bench for class_search_ctrl: bench-side class ROM plus a distance model.
// Directed queries, random classes, backpressure, ignored pulses and reset.
module tb_class_search_ctrl;
    import hdc_search_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          query_valid = 1'b0;
    logic                          query_ready;
    logic [DI_PARALLEL_W_BITS-1:0] query_frame = '0;
    logic [CLS_W-1:0]              frame_id;
    logic [FRM_W-1:0]              frame_index;
    logic [DI_PARALLEL_W_BITS-1:0] class_vec_in;
    logic                          result_valid;
    logic                          result_ready = 1'b0;
    logic [CLS_W-1:0]              result_class;
    logic [DIST_W-1:0]             result_dist;
    logic                          busy;

    logic [63:0] rom [NUM_CLASSES][NUM_FRAMES];
    logic [63:0] qry [NUM_FRAMES];
    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    class_search_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .query_frame  (query_frame),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_dist  (result_dist),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign class_vec_in = rom[frame_id][frame_index];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: total Hamming distance per class, minimum, lowest index wins.
    task automatic model(output int bc, output int bd);
        int d;
        bc = 0;
        bd = 1 << 30;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            d = 0;
            for (int f = 0; f < NUM_FRAMES; f++)
                d += $countones(qry[f] ^ rom[c][f]);
            if (d < bd) begin
                bd = d;
                bc = c;
            end
        end
    endtask

    task automatic send_query(input string tag, input int gapmax,
                              output int hs);
        int n;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            query_valid = 1'b1;
            query_frame = qry[f];
            n = 0;
            while (!query_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!query_ready) chk({tag, " query_ready timeout"}, 0, 1);
            @(posedge clk); #1;
            hs = cyc;
            query_valid = 1'b0;
            query_frame = {$urandom, $urandom};
            if (gapmax > 0 && f < NUM_FRAMES - 1)
                repeat ($urandom_range(gapmax, 1)) begin
                    @(posedge clk); #1;
                end
        end
    endtask

    task automatic run_query(input string tag, input int gapmax,
                             input int hold, input bit junk,
                             output int rc, output int rd);
        int hs, n, ec, ed;
        logic [CLS_W-1:0]  c0;
        logic [DIST_W-1:0] d0;
        model(ec, ed);
        send_query(tag, gapmax, hs);
        if (junk) begin
            query_valid = 1'b1;
            query_frame = {$urandom, $urandom};
        end
        n = 0;
        while (!result_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " result_valid"}, result_valid, 1);
        chk({tag, " latency"}, cyc - hs, 26);
        chk({tag, " class"}, result_class, ec);
        chk({tag, " dist"}, result_dist, ed);
        c0 = result_class;
        d0 = result_dist;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == 0 || i == hold - 1) begin
                chk({tag, " hold valid"}, result_valid, 1);
                chk({tag, " hold class"}, result_class, c0);
                chk({tag, " hold dist"}, result_dist, d0);
                chk({tag, " hold qready"}, query_ready, 0);
            end
        end
        query_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({tag, " valid drop"}, result_valid, 0);
        chk({tag, " qready back"}, query_ready, 1);
        rc = result_class;
        rd = result_dist;
    endtask

    initial begin
        int rc, rd, rc2, rd2, hs;
        logic [63:0] save [NUM_FRAMES];

        for (int f = 0; f < NUM_FRAMES; f++) begin
            rom[1][f] = 64'hD9BFE198D232075B;
            for (int c = 2; c < NUM_CLASSES; c++)
                rom[c][f] = {$urandom, $urandom};
        end
        rom[0][0] = 64'h74C27F4985AC5CFA;
        rom[0][1] = 64'h66C27F4985AC5CFA;
        rom[0][2] = 64'h74C27F4985AC5CFA;

        #1;
        chk("rst qready", query_ready, 0);
        chk("rst frame_id", frame_id, 0);
        chk("rst frame_index", frame_index, 0);
        chk("rst result_valid", result_valid, 0);
        chk("rst result_class", result_class, 0);
        chk("rst result_dist", result_dist, 0);
        chk("rst busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst qready", query_ready, 1);

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = rom[1][f];
        run_query("class1", 0, 0, 0, rc, rd);
        chk("class1 exact class", rc, 1);
        chk("class1 exact dist", rd, 0);

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = rom[0][f];
        run_query("class0", 0, 0, 0, rc, rd);
        chk("class0 exact class", rc, 0);
        chk("class0 exact dist", rd, 0);

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = rom[1][f];
        qry[2][0] = ~qry[2][0];
        run_query("flip", 0, 0, 0, rc, rd);
        chk("flip exact class", rc, 1);
        chk("flip exact dist", rd, 1);

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = '0;
        run_query("zeros", 0, 0, 0, rc, rd);

        for (int f = 0; f < NUM_FRAMES; f++) begin
            save[f] = rom[5][f];
            rom[5][f] = rom[2][f];
            qry[f] = rom[2][f] ^ (64'h1 << $urandom_range(63, 0));
        end
        run_query("tie", 0, 0, 0, rc, rd);
        chk("tie exact class", rc, 2);
        for (int f = 0; f < NUM_FRAMES; f++) rom[5][f] = save[f];

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = {$urandom, $urandom};
        run_query("backpressure", 0, 10, 1, rc, rd);
        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = rom[3][f] ^ {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        run_query("after-bp", 0, 0, 0, rc, rd);

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = {$urandom, $urandom};
        send_query("midrst", 0, hs);
        repeat (10) @(posedge clk);
        #2;
        chk("midrst busy before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst qready", query_ready, 0);
        chk("midrst frame_id", frame_id, 0);
        chk("midrst frame_index", frame_index, 0);
        chk("midrst busy", busy, 0);
        chk("midrst result_valid", result_valid, 0);
        chk("midrst result_dist", result_dist, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rc2 = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid) rc2++;
        end
        chk("midrst no result", rc2, 0);

        for (int f = 0; f < NUM_FRAMES; f++) qry[f] = rom[6][f] ^ {$urandom, $urandom} & {$urandom, $urandom};
        run_query("fresh", 0, 0, 0, rc, rd);
        run_query("gapped", 3, 0, 0, rc2, rd2);
        chk("gapped same class", rc2, rc);
        chk("gapped same dist", rd2, rd);

        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < NUM_FRAMES; f++) qry[f] = {$urandom, $urandom};
            run_query("random", k, $urandom_range(3, 0), k[0], rc, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
